// File: rtl/ctl_trigger.sv
// Light-gun trigger conditioner: synchronises and debounces the raw trigger, then
// fires one fixed-width shot strobe per pull with a cooldown and a dry-fire click.
module ctl_trigger #(
  parameter int DEBOUNCE_CYCLES   = 650_000,
  parameter int SHOT_PULSE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES   = 16_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_score,
  input  logic       trigger_in,
  input  logic       no_ammo,
  output logic       trigger_db,
  output logic       shot_fired,
  output logic       dry_fire,
  output logic       ready,
  output logic [7:0] shot_ctr
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PULSE_W = $clog2(SHOT_PULSE_CYCLES + 1);
  localparam int CD_W    = $clog2(COOLDOWN_CYCLES + 1);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(SHOT_PULSE_CYCLES - 1);
  localparam logic [CD_W-1:0]    CD_LAST    = CD_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    COOLDOWN,
    WAIT_RELEASE
  } state_t;

  state_t               state, state_nx;
  logic                 sync_p0, trig_s;
  logic [DB_W-1:0]      db_cnt;
  logic [PULSE_W-1:0]   pulse_cnt, pulse_nx;
  logic [CD_W-1:0]      cd_cnt, cd_nx;
  logic                 shot_nx, dry_nx;
  logic [7:0]           ctr_nx;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchroniser, then debounce against the current level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0    <= 1'b0;
      trig_s     <= 1'b0;
      trigger_db <= 1'b0;
      db_cnt     <= '0;
    end else if (reset_score) begin
      sync_p0    <= 1'b0;
      trig_s     <= 1'b0;
      trigger_db <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync_p0 <= trigger_in;
      trig_s  <= sync_p0;
      if (trig_s == trigger_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        trigger_db <= trig_s;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Shot FSM: next state and next registered outputs
  always_comb begin
    state_nx = state;
    shot_nx  = shot_fired;
    dry_nx   = 1'b0;
    ctr_nx   = shot_ctr;
    pulse_nx = pulse_cnt;
    cd_nx    = cd_cnt;
    case (state)
      IDLE: begin
        if (trigger_db) begin
          if (!no_ammo) begin
            state_nx = FIRE;
            shot_nx  = 1'b1;
            pulse_nx = '0;
            ctr_nx   = sat_inc(shot_ctr);
          end else begin
            state_nx = WAIT_RELEASE;
            dry_nx   = 1'b1;
          end
        end
      end
      FIRE: begin
        if (pulse_cnt == PULSE_LAST) begin
          state_nx = COOLDOWN;
          shot_nx  = 1'b0;
          cd_nx    = '0;
        end else begin
          pulse_nx = pulse_cnt + 1'b1;
        end
      end
      COOLDOWN: begin
        // A trigger still held at expiry must be released before the next shot
        if (cd_cnt == CD_LAST) begin
          state_nx = trigger_db ? WAIT_RELEASE : IDLE;
        end else begin
          cd_nx = cd_cnt + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!trigger_db) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p2: FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shot_fired <= 1'b0;
      dry_fire   <= 1'b0;
      shot_ctr   <= 8'd0;
      pulse_cnt  <= '0;
      cd_cnt     <= '0;
    end else if (reset_score) begin
      state      <= IDLE;
      shot_fired <= 1'b0;
      dry_fire   <= 1'b0;
      shot_ctr   <= 8'd0;
      pulse_cnt  <= '0;
      cd_cnt     <= '0;
    end else begin
      state      <= state_nx;
      shot_fired <= shot_nx;
      dry_fire   <= dry_nx;
      shot_ctr   <= ctr_nx;
      pulse_cnt  <= pulse_nx;
      cd_cnt     <= cd_nx;
    end
  end

  assign ready = (state == IDLE);

endmodule

// File: tb/tb_ctl_trigger.sv
// Bench for ctl_trigger: scenario tasks plus randomized trigger traffic, all checked
// cycle by cycle against a timestamp-based model of the gun behaviour.
module tb_ctl_trigger;

  localparam int D = 4;
  localparam int P = 3;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reset_score = 1'b0;
  logic       trigger_in = 1'b0;
  logic       no_ammo = 1'b0;
  logic       trigger_db, shot_fired, dry_fire, ready;
  logic [7:0] shot_ctr;
  logic [11:0] dut_vec;

  int tests = 0;
  int fails = 0;

  ctl_trigger #(
    .DEBOUNCE_CYCLES  (D),
    .SHOT_PULSE_CYCLES(P),
    .COOLDOWN_CYCLES  (C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reset_score(reset_score),
    .trigger_in (trigger_in),
    .no_ammo    (no_ammo),
    .trigger_db (trigger_db),
    .shot_fired (shot_fired),
    .dry_fire   (dry_fire),
    .ready      (ready),
    .shot_ctr   (shot_ctr)
  );

  always #5 clk = ~clk;

  assign dut_vec = {trigger_db, shot_fired, dry_fire, ready, shot_ctr};

  // Reference model: edge counter, shot timestamp, run length of disagreement
  int cyc = 0;
  bit m_s1, m_s2, m_db;
  int m_run;
  bit m_active;
  int m_shot_edge;
  bit m_wait;
  int m_dry_edge;
  int m_ctr;

  function automatic void m_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
    m_active = 0; m_shot_edge = 0; m_wait = 0;
    m_dry_edge = -1; m_ctr = 0;
  endfunction

  function automatic void m_update(input bit tin, input bit na, input bit rs);
    bit old_db;
    cyc++;
    if (rs) begin
      m_reset();
      return;
    end
    old_db = m_db;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == D) begin
        m_db  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = tin;
    if (m_active) begin
      if (cyc - m_shot_edge == P + C) begin
        m_active = 0;
        m_wait   = old_db;
      end
    end else if (m_wait) begin
      if (!old_db) m_wait = 0;
    end else if (old_db) begin
      if (!na) begin
        m_active    = 1;
        m_shot_edge = cyc;
        if (m_ctr < 255) m_ctr++;
      end else begin
        m_wait     = 1;
        m_dry_edge = cyc;
      end
    end
  endfunction

  function automatic logic [11:0] m_vec();
    logic [7:0] c;
    c = m_ctr[7:0];
    return {m_db, (m_active && (cyc - m_shot_edge) < P), (m_dry_edge == cyc),
            (!m_active && !m_wait), c};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_update(trigger_in, no_ammo, reset_score || rst);
    @(negedge clk);
  endtask

  task automatic do_reset();
    trigger_in = 0; no_ammo = 0; reset_score = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    m_reset();
    #1;
    tests++;
    if (dut_vec !== 12'b0001_0000_0000) begin
      fails++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 12'b0001_0000_0000);
    end
    tick(); tick();
    rst = 0;
    tick();
    tests++;
    if (dut_vec !== m_vec()) begin
      fails++; $display("FAIL reset_release got=%h exp=%h", dut_vec, m_vec());
    end
  endtask

  task automatic test_clean();
    int lat = 0;
    int shot_cyc = 0;
    do_reset();
    trigger_in = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      tests++;
      if (dut_vec !== m_vec()) begin
        fails++; $display("FAIL clean_lock cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec());
      end
      if (lat == 0 && trigger_db) lat = k;
      if (shot_fired) shot_cyc++;
    end
    tests++;
    if (lat !== 6) begin fails++; $display("FAIL clean_latency got=%0d exp=6", lat); end
    tests++;
    if (shot_cyc !== P) begin fails++; $display("FAIL clean_pulse got=%0d exp=%0d", shot_cyc, P); end
    tests++;
    if (shot_ctr !== 8'd1) begin fails++; $display("FAIL clean_ctr got=%0d exp=1", shot_ctr); end
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL clean_held_ready got=%b exp=0", ready); end
    trigger_in = 0;
    for (int k = 0; k < 15; k++) tick();
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL clean_release_ready got=%b exp=1", ready); end
  endtask

  task automatic test_bounce();
    bit db_seen = 0;
    bit shot_seen = 0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      trigger_in = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
      tick();
      tests++;
      if (dut_vec !== m_vec()) begin
        fails++; $display("FAIL bounce_lock cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec());
      end
      if (trigger_db) db_seen = 1;
      if (shot_fired) shot_seen = 1;
    end
    tests++;
    if (db_seen !== 1'b0) begin fails++; $display("FAIL bounce_db got=%b exp=0", db_seen); end
    tests++;
    if (shot_seen !== 1'b0) begin fails++; $display("FAIL bounce_shot got=%b exp=0", shot_seen); end
    tests++;
    if (shot_ctr !== 8'd0) begin fails++; $display("FAIL bounce_ctr got=%0d exp=0", shot_ctr); end
  endtask

  task automatic test_cooldown();
    int shots = 0;
    bit prev = 0;
    bit db_dropped = 0;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      trigger_in = (k < 8 || k >= 12);
      tick();
      tests++;
      if (dut_vec !== m_vec()) begin
        fails++; $display("FAIL cool_lock cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec());
      end
      if (shot_fired && !prev) shots++;
      prev = shot_fired;
      if (k > 8 && k < 17 && !trigger_db) db_dropped = 1;
    end
    tests++;
    if (db_dropped !== 1'b1) begin fails++; $display("FAIL cool_repull got=%b exp=1", db_dropped); end
    tests++;
    if (shots !== 1) begin fails++; $display("FAIL cool_shots got=%0d exp=1", shots); end
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL cool_held_ready got=%b exp=0", ready); end
    trigger_in = 0;
    for (int k = 0; k < 15; k++) tick();
    tests++;
    if (ready !== 1'b1 || shot_ctr !== 8'd1) begin
      fails++; $display("FAIL cool_release got=%b/%0d exp=1/1", ready, shot_ctr);
    end
  endtask

  task automatic test_dry_fire();
    int dry_cyc = 0;
    int shot_cyc = 0;
    do_reset();
    no_ammo = 1;
    trigger_in = 1;
    for (int k = 0; k < 32; k++) begin
      if (k == 20) trigger_in = 0;
      tick();
      tests++;
      if (dut_vec !== m_vec()) begin
        fails++; $display("FAIL dry_lock cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec());
      end
      if (dry_fire) dry_cyc++;
      if (shot_fired) shot_cyc++;
    end
    tests++;
    if (dry_cyc !== 1) begin fails++; $display("FAIL dry_pulse got=%0d exp=1", dry_cyc); end
    tests++;
    if (shot_cyc !== 0 || shot_ctr !== 8'd0) begin
      fails++; $display("FAIL dry_noshot got=%0d/%0d exp=0/0", shot_cyc, shot_ctr);
    end
    no_ammo = 0;
  endtask

  task automatic test_saturate();
    int shots = 0;
    bit prev = 0;
    do_reset();
    for (int s = 0; s < 260; s++) begin
      for (int k = 0; k < 22; k++) begin
        trigger_in = (k < 10);
        tick();
        tests++;
        if (dut_vec !== m_vec()) begin
          fails++; $display("FAIL sat_lock cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec());
        end
        if (shot_fired && !prev) shots++;
        prev = shot_fired;
      end
    end
    tests++;
    if (shots !== 260) begin fails++; $display("FAIL sat_shots got=%0d exp=260", shots); end
    tests++;
    if (shot_ctr !== 8'd255) begin fails++; $display("FAIL sat_ctr got=%0d exp=255", shot_ctr); end
    reset_score = 1;
    tick();
    reset_score = 0;
    tests++;
    if (dut_vec !== 12'b0001_0000_0000) begin
      fails++; $display("FAIL sat_reset_score got=%h exp=%h", dut_vec, 12'b0001_0000_0000);
    end
  endtask

  task automatic test_async_rst();
    int waited = 0;
    do_reset();
    trigger_in = 1;
    while (!shot_fired && waited < 20) begin
      tick();
      waited++;
    end
    tests++;
    if (!shot_fired) begin
      fails++; $display("FAIL arst_shot_timeout got=%b exp=1", shot_fired);
    end
    #2 rst = 1;
    m_reset();
    #1;
    tests++;
    if (dut_vec !== 12'b0001_0000_0000) begin
      fails++; $display("FAIL arst_immediate got=%h exp=%h", dut_vec, 12'b0001_0000_0000);
    end
    tick(); tick();
    trigger_in = 0;
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests++;
      if (dut_vec !== m_vec()) begin
        fails++; $display("FAIL arst_lock cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_random();
    int left = 3000;
    int len;
    do_reset();
    while (left > 0) begin
      trigger_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) no_ammo = ~no_ammo;
      reset_score = ($urandom_range(0, 40) == 0);
      len = $urandom_range(1, 14);
      for (int j = 0; j < len; j++) begin
        tick();
        reset_score = 0;
        left--;
        tests++;
        if (dut_vec !== m_vec()) begin
          fails++; $display("FAIL rand_lock cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec());
        end
      end
    end
    no_ammo = 0;
    trigger_in = 0;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_cooldown();
    test_dry_fire();
    test_saturate();
    test_async_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
